// File: rtl/posit_conv_arbiter.sv
// Round-robin arbiter sharing one combinational posit-to-float converter among NREQ requesters.
// Latency: handshake at edge k -> out_valid after edge k+1; one result per cycle while out_ready holds.
// Backpressure: two-entry pipeline, req_ready drops when both stages are full; POSIT_CONV_STATS_EN adds counters.
module posit_conv_arbiter #(
    parameter int N    = 32,
    parameter int es   = 2,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*N-1:0]    req_posit,
    output logic [NREQ-1:0]      req_ready,
    output logic [N-1:0]         cv_posit,
    input  logic [N-1:0]         cv_float,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_float,
    output logic [IDW-1:0]       out_id,
    input  logic                 flush,
    output logic [31:0]          stat_conv,
    output logic [15:0]          stat_nar
);

    // es only matters to the external converter.
    logic unused_es;
    assign unused_es = (es != 0);

    logic           s1_v_q, s1_v_d;
    logic [N-1:0]   s1_posit_q, s1_posit_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_float_q, out_float_d;
    logic [IDW-1:0] out_id_q, out_id_d;

    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           any_vld;
    logic [N-1:0]   win_posit;
    logic           adv2;
    logic           accept;
    logic           hs;

    // Search starts just after the last winner, so the pointer rotates priority.
    always_comb begin
        win_id  = ptr_q;
        cand    = '0;
        any_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!any_vld && req_valid[cand]) begin
                win_id  = cand;
                any_vld = 1'b1;
            end
        end
    end

    assign win_posit = req_posit[win_id*N +: N];
    assign adv2      = s1_v_q & (~out_valid_q | out_ready);
    assign accept    = ~s1_v_q | adv2;
    assign hs        = rst_n & ~flush & accept & any_vld;
    assign req_ready = hs ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_posit_d  = s1_posit_q;
        s1_id_d     = s1_id_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_float_d = out_float_q;
        out_id_d    = out_id_q;
        if (flush) begin
            s1_v_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (hs) begin
                s1_v_d     = 1'b1;
                s1_posit_d = win_posit;
                s1_id_d    = win_id;
                ptr_d      = win_id;
            end else if (accept) begin
                s1_v_d = 1'b0;
            end
            if (adv2) begin
                out_valid_d = 1'b1;
                out_float_d = cv_float;
                out_id_d    = s1_id_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_posit_q  <= '0;
            s1_id_q     <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            out_valid_q <= 1'b0;
            out_float_q <= '0;
            out_id_q    <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_posit_q  <= s1_posit_d;
            s1_id_q     <= s1_id_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_float_q <= out_float_d;
            out_id_q    <= out_id_d;
        end
    end

    assign cv_posit  = s1_posit_q;
    assign out_valid = out_valid_q;
    assign out_float = out_float_q;
    assign out_id    = out_id_q;

`ifdef POSIT_CONV_STATS_EN
    logic [31:0] stat_conv_q, stat_conv_d;
    logic [15:0] stat_nar_q, stat_nar_d;
    logic        pop;
    logic        is_nar;

    // A flushed entry never reaches the consumer, so it is not counted.
    assign pop    = out_valid_q & out_ready & ~flush;
    assign is_nar = (win_posit == {1'b1, {(N-1){1'b0}}});

    always_comb begin
        stat_conv_d = stat_conv_q;
        stat_nar_d  = stat_nar_q;
        if (pop && (stat_conv_q != '1)) begin
            stat_conv_d = stat_conv_q + 32'd1;
        end
        if (hs && is_nar && (stat_nar_q != '1)) begin
            stat_nar_d = stat_nar_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_conv_q <= '0;
            stat_nar_q  <= '0;
        end else begin
            stat_conv_q <= stat_conv_d;
            stat_nar_q  <= stat_nar_d;
        end
    end

    assign stat_conv = stat_conv_q;
    assign stat_nar  = stat_nar_q;
`else
    assign stat_conv = '0;
    assign stat_nar  = '0;
`endif

endmodule

// File: tb/tb_posit_conv_arbiter.sv
// Scoreboard bench for posit_conv_arbiter: stimulus pushes expected results, a negedge monitor pops them.
module tb_posit_conv_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [31:0] PV [4] = '{32'h40000000, 32'h48000000, 32'h50000000, 32'h58000000};
    localparam logic [31:0] FV [4] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_posit;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      cv_posit;
    logic [N-1:0]      cv_float;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_float;
    logic [IDW-1:0]    out_id;
    logic              flush;
    logic [31:0]       stat_conv;
    logic [15:0]       stat_nar;
    logic [N-1:0]      posit_in [NREQ];

    always #5 clk = ~clk;

    assign req_posit = {posit_in[3], posit_in[2], posit_in[1], posit_in[0]};

    // Stand-in converter: hand-decoded posit32 (es=2) values used by the vectors.
    function automatic logic [31:0] conv(input logic [31:0] p);
        case (p)
            32'h40000000: return 32'h3F800000;
            32'h48000000: return 32'h40000000;
            32'h50000000: return 32'h40800000;
            32'h58000000: return 32'h41000000;
            32'h80000000: return 32'h7FC00000;
            default:      return 32'h00000000;
        endcase
    endfunction
    assign cv_float = conv(cv_posit);

    posit_conv_arbiter #(.N(N), .es(2), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_posit(req_posit),
        .req_ready(req_ready), .cv_posit(cv_posit), .cv_float(cv_float),
        .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float),
        .out_id(out_id), .flush(flush), .stat_conv(stat_conv), .stat_nar(stat_nar)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int id, input logic [31:0] f);
        exp_t e;
        e.id = IDW'(id);
        e.f  = f;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got id %0d float %h, required no output", out_id, out_float);
            end else begin
                mon_e = sb.pop_front();
                check("out_id", 64'(out_id), 64'(mon_e.id));
                check("out_float", 64'(out_float), 64'(mon_e.f));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset;
        out_ready = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < NREQ; i++) posit_in[i] = PV[i];
        tick();
        tick();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_cv_posit", 64'(cv_posit), 64'd0);
        check("rst_stat_conv", 64'(stat_conv), 64'd0);
        check("rst_stat_nar", 64'(stat_nar), 64'd0);

        // Single request from requester 2.
        rst_n       = 1'b1;
        posit_in[2] = 32'h40000000;
        req_valid   = 4'b0100;
        out_ready   = 1'b1;
        #1;
        check("single_grant", 64'(req_ready), 64'(4'b0100));
        push(2, 32'h3F800000);
        tick();
        req_valid = '0;
        #1;
        check("single_cv_posit", 64'(cv_posit), 64'h40000000);
        check("single_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("single_out_valid", 64'(out_valid), 64'd1);
        tick();
        check("single_out_clear", 64'(out_valid), 64'd0);
        drain();

        // Fairness with every requester asserting.
        do_reset();
        for (int i = 0; i < NREQ; i++) posit_in[i] = PV[i];
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("fair_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            push(c % 4, FV[c % 4]);
            tick();
        end
        req_valid = '0;
        drain();

        // Backpressure fills both stages.
        do_reset();
        req_valid = 4'b0011;
        #1;
        check("bp_grant0", 64'(req_ready), 64'(4'b0001));
        push(0, FV[0]);
        tick();
        check("bp_grant1", 64'(req_ready), 64'(4'b0010));
        push(1, FV[1]);
        tick();
        check("bp_full_ready", 64'(req_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_id", 64'(out_id), 64'd0);
        tick();
        tick();
        check("bp_hold_ready", 64'(req_ready), 64'd0);
        check("bp_hold_float", 64'(out_float), 64'(FV[0]));
        req_valid = '0;
        out_ready = 1'b1;
        drain();

        // Flush with both stages full.
        do_reset();
        req_valid = 4'b0011;
        tick();
        tick();
        flush     = 1'b1;
        req_valid = 4'b0100;
        #1;
        check("flush_ready_full", 64'(req_ready), 64'd0);
        tick();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_ready_empty", 64'(req_ready), 64'd0);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        tick();
        check("flush_s1_empty", 64'(out_valid), 64'd0);
        req_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        check("flush_resume_ptr", 64'(req_ready), 64'(4'b0100));
        push(2, FV[2]);
        tick();
        req_valid = '0;
        drain();

        // Reset while a result is pending.
        out_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        check("mid_grant3", 64'(req_ready), 64'(4'b1000));
        tick();
        req_valid = '0;
        tick();
        check("mid_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_id", 64'(out_id), 64'd0);
        check("mid_rst_cv", 64'(cv_posit), 64'd0);
        req_valid = 4'hF;
        #1;
        check("mid_first_grant", 64'(req_ready), 64'(4'b0001));
        out_ready = 1'b1;
        push(0, FV[0]);
        tick();
        req_valid = '0;
        drain();

        // Statistics: three conversions, one NaR.
        do_reset();
        posit_in[0] = 32'h40000000;
        posit_in[1] = 32'h80000000;
        posit_in[2] = 32'h48000000;
        req_valid   = 4'b0111;
        out_ready   = 1'b1;
        #1;
        check("stat_grant0", 64'(req_ready), 64'(4'b0001));
        push(0, 32'h3F800000);
        tick();
        check("stat_grant1", 64'(req_ready), 64'(4'b0010));
        push(1, 32'h7FC00000);
        tick();
        check("stat_grant2", 64'(req_ready), 64'(4'b0100));
        push(2, 32'h40000000);
        tick();
        req_valid = '0;
        drain();
        tick();
`ifdef POSIT_CONV_STATS_EN
        check("stat_conv", 64'(stat_conv), 64'd3);
        check("stat_nar", 64'(stat_nar), 64'd1);
`else
        check("stat_conv_off", 64'(stat_conv), 64'd0);
        check("stat_nar_off", 64'(stat_nar), 64'd0);
`endif

        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
